// File: rtl/floo_pkg.sv
// Shared helpers for the floo flow-control blocks.
// Holds small elaboration-time utilities only.
package floo_pkg;

  function automatic int unsigned floo_max(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/floo_credit_cnt_slice.sv
// One saturating credit counter for a single virtual channel.
// Flags this-cycle underflow/overflow; the top makes it sticky.
module floo_credit_cnt_slice #(
  parameter int unsigned NumCredits = 3,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ready_o,
  output logic                at_max_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  logic                empty;
  logic                full;
  logic                inc_only;
  logic                dec_only;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == MaxCnt);
  assign inc_only = inc_i && !dec_i;
  assign dec_only = dec_i && !inc_i;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    unique case (1'b1)
      inc_only && full:   err_o = 1'b1;
      inc_only && !full:  cnt_d = cnt_q + CntWidth'(1);
      dec_only && empty:  err_o = 1'b1;
      dec_only && !empty: cnt_d = cnt_q - CntWidth'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= MaxCnt;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign ready_o  = !empty;
  assign at_max_o = full;

endmodule

// File: rtl/floo_vc_credit_counter.sv
// Per-VC credit tracking for a router output port.
// Gates arbiter ready on downstream buffer space.
module floo_vc_credit_counter
  import floo_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumCredits      = 3,
  parameter bit          RegCreditIn     = 1'b0,
  localparam int unsigned CntWidth = $clog2(NumCredits + 1),
  localparam int unsigned IdWidth  =
    floo_max(1, $clog2(NumVirtChannels))
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumVirtChannels-1:0]          sent_i,
  input  logic                                credit_valid_i,
  input  logic [IdWidth-1:0]                  credit_id_i,
  output logic [NumVirtChannels-1:0]          ready_o,
  output logic [NumVirtChannels*CntWidth-1:0] credits_o,
  output logic                                all_returned_o,
  output logic                                err_o
);

  logic                       cred_valid;
  logic [IdWidth-1:0]         cred_id;
  logic                       bad_id;
  logic                       multi_hot;
  logic [NumVirtChannels-1:0] inc;
  logic [NumVirtChannels-1:0] at_max;
  logic [NumVirtChannels-1:0] slice_err;
  logic                       err_q;

  if (RegCreditIn) begin : g_cred_reg
    logic               valid_q;
    logic [IdWidth-1:0] id_q;

    // Cuts the inter-router path at the cost of one cycle.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        id_q    <= '0;
      end else begin
        valid_q <= credit_valid_i;
        id_q    <= credit_id_i;
      end
    end

    assign cred_valid = valid_q;
    assign cred_id    = id_q;
  end else begin : g_cred_comb
    assign cred_valid = credit_valid_i;
    assign cred_id    = credit_id_i;
  end

  if (NumVirtChannels == 1) begin : g_single
    assign bad_id = 1'b0;
    assign inc    = cred_valid;
  end else begin : g_multi
    assign bad_id = cred_valid &&
      ({1'b0, cred_id} >= (IdWidth + 1)'(NumVirtChannels));
    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_dec
      assign inc[v] = cred_valid && !bad_id &&
        (cred_id == IdWidth'(v));
    end
  end

  assign multi_hot =
    ((sent_i & (sent_i - NumVirtChannels'(1))) != '0);

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    floo_credit_cnt_slice #(
      .NumCredits (NumCredits),
      .CntWidth   (CntWidth)
    ) i_slice (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .inc_i    (inc[v]),
      .dec_i    (sent_i[v]),
      .cnt_o    (credits_o[v*CntWidth +: CntWidth]),
      .ready_o  (ready_o[v]),
      .at_max_o (at_max[v]),
      .err_o    (slice_err[v])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|slice_err) | bad_id | multi_hot;
    end
  end

  assign err_o          = err_q;
  assign all_returned_o = &at_max;

endmodule

// File: tb/tb_floo_vc_credit_counter.sv
// Directed checks of the VC credit counter, with and
// without the registered credit input.
module tb_floo_vc_credit_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sent;
  logic       cv;
  logic [0:0] cid;

  logic [1:0] rdy,  rdy_r;
  logic [3:0] cr,   cr_r;
  logic       allr, allr_r;
  logic       err,  err_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  floo_vc_credit_counter #(
    .NumVirtChannels (2),
    .NumCredits      (3),
    .RegCreditIn     (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sent_i         (sent),
    .credit_valid_i (cv),
    .credit_id_i    (cid),
    .ready_o        (rdy),
    .credits_o      (cr),
    .all_returned_o (allr),
    .err_o          (err)
  );

  floo_vc_credit_counter #(
    .NumVirtChannels (2),
    .NumCredits      (3),
    .RegCreditIn     (1'b1)
  ) dut_r (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sent_i         (sent),
    .credit_valid_i (cv),
    .credit_id_i    (cid),
    .ready_o        (rdy_r),
    .credits_o      (cr_r),
    .all_returned_o (allr_r),
    .err_o          (err_r)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sent = 2'b00;
    cv   = 1'b0;
    cid  = 1'b0;
  endtask

  task automatic state(input string tag,
                       input logic [3:0] c,
                       input logic [1:0] r,
                       input logic e);
    chk({tag, "_cr"},  cr,    c);
    chk({tag, "_rdy"}, rdy,   r);
    chk({tag, "_err"}, err,   e);
    chk({tag, "_crR"}, cr_r,  c);
    chk({tag, "_rdR"}, rdy_r, r);
    chk({tag, "_erR"}, err_r, e);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    state("reset", 4'b1111, 2'b11, 1'b0);
    chk("reset_all", allr, 1);
    chk("reset_allR", allr_r, 1);

    // drain VC0: 3 -> 2 -> 1 -> 0
    sent = 2'b01;
    tick();
    state("drain1", 4'b1110, 2'b11, 1'b0);
    chk("drain1_all", allr, 0);
    tick();
    state("drain2", 4'b1101, 2'b11, 1'b0);
    tick();
    state("drain3", 4'b1100, 2'b10, 1'b0);

    // credit to VC0 at zero
    idle();
    cv = 1'b1;
    tick();
    idle();
    chk("ret_cr", cr, 4'b1101);
    chk("ret_rdy", rdy, 2'b11);
    chk("ret_rdyR_early", rdy_r, 2'b10);
    tick();
    chk("ret_rdyR_late", rdy_r, 2'b11);
    chk("ret_crR", cr_r, 4'b1101);

    // VC1 to 2, then send+credit in same cycle
    sent = 2'b10;
    tick();
    state("vc1_two", 4'b1001, 2'b11, 1'b0);
    cv  = 1'b1;
    cid = 1'b1;
    tick();
    idle();
    chk("same_cr", cr, 4'b1001);
    chk("same_err", err, 0);
    chk("same_crR", cr_r, 4'b0101);
    tick();
    state("same_settle", 4'b1001, 2'b11, 1'b0);

    // refill VC0 and overflow it
    cv = 1'b1;
    tick();
    tick();
    chk("fill_cr", cr, 4'b1011);
    chk("fill_err", err, 0);
    tick();
    idle();
    chk("ovf_cr", cr, 4'b1011);
    chk("ovf_err", err, 1);
    chk("ovf_errR_pre", err_r, 0);
    tick();
    state("ovf_late", 4'b1011, 2'b11, 1'b1);
    tick();
    state("ovf_sticky", 4'b1011, 2'b11, 1'b1);

    // fresh run, underflow VC0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    state("rst2", 4'b1111, 2'b11, 1'b0);
    sent = 2'b01;
    repeat (3) tick();
    state("udf_pre", 4'b1100, 2'b10, 1'b0);
    tick();
    idle();
    state("udf", 4'b1100, 2'b10, 1'b1);

    // VC0=1, VC1=0 with err set, then reset
    cv = 1'b1;
    tick();
    idle();
    tick();
    sent = 2'b10;
    repeat (3) tick();
    idle();
    state("mid", 4'b0001, 2'b01, 1'b1);
    chk("mid_all", allr, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    state("mid_rst", 4'b1111, 2'b11, 1'b0);
    chk("mid_rst_all", allr, 1);

    // multi-hot send: both decrement, err set
    sent = 2'b11;
    tick();
    idle();
    state("multi", 4'b1010, 2'b11, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected done");
    $fatal(1);
  end

endmodule
